// File: rtl/bus_watchdog.sv
// bus_watchdog: bus-cycle timeout monitor. While as_n is low and dtack_n has
// not answered, counts clocks against a limit latched at cycle start and
// drives berr_n low on timeout until the master drops as_n.
// Optional feature macro: WATCHDOG_EVCNT_EN adds the saturating timeout
// event counter output evcnt.
module bus_watchdog #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned EVT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             as_n,
   input  logic             dtack_n,
   input  logic [CNT_W-1:0] limit,
   output logic             berr_n,
   output logic             busy
`ifdef WATCHDOG_EVCNT_EN
   ,
   output logic [EVT_W-1:0] evcnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_BERR  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] lim_q, lim_d;
   logic             armed_q, armed_d;
   logic             berr_n_q, berr_n_d;
   logic             busy_q, busy_d;

`ifdef WATCHDOG_EVCNT_EN
   logic [EVT_W-1:0] ev_q, ev_d;
`else
   logic             unused_evt_w;
   assign unused_evt_w = (EVT_W == 0);
`endif

   // State and output registers; reset aborts any bus cycle in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         lim_q    <= '0;
         armed_q  <= 1'b0;
         berr_n_q <= 1'b1;
         busy_q   <= 1'b0;
`ifdef WATCHDOG_EVCNT_EN
         ev_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lim_q    <= lim_d;
         armed_q  <= armed_d;
         berr_n_q <= berr_n_d;
         busy_q   <= busy_d;
`ifdef WATCHDOG_EVCNT_EN
         ev_q     <= ev_d;
`endif
      end
   end

   // Next-state logic; outputs are derived from the next state so they
   // change on the same edge as the state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      // After reset, a cycle left asserted across reset must not be watched:
      // require one as_n high sample before accepting a new cycle
      armed_d = armed_q | as_n;
`ifdef WATCHDOG_EVCNT_EN
      ev_d    = ev_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (armed_q && !as_n && dtack_n) begin
               state_d = ST_COUNT;
               lim_d   = limit;
            end
         end
         ST_COUNT: begin
            if (as_n || !dtack_n) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (lim_q == '0) begin
               cnt_d = cnt_q;
            end else if (cnt_q == lim_q - CNT_W'(1)) begin
               // Timeout outranks a kick on the same edge
               state_d = ST_BERR;
`ifdef WATCHDOG_EVCNT_EN
               if (ev_q != {EVT_W{1'b1}}) begin
                  ev_d = ev_q + EVT_W'(1);
               end
`endif
            end else if (clr) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BERR: begin
            if (as_n) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      berr_n_d = (state_d != ST_BERR);
      busy_d   = (state_d != ST_IDLE);
   end

   assign berr_n = berr_n_q;
   assign busy   = busy_q;
`ifdef WATCHDOG_EVCNT_EN
   assign evcnt  = ev_q;
`endif

endmodule

// File: tb/tb_bus_watchdog.sv
// Testbench for bus_watchdog: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a deadline-based
// behavioural model.
module tb_bus_watchdog;

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned EVT_W  = 4;
   localparam int          EV_MAX = (1 << EVT_W) - 1;

   logic             clk     = 1'b0;
   logic             rst     = 1'b1;
   logic             clr     = 1'b0;
   logic             as_n    = 1'b1;
   logic             dtack_n = 1'b1;
   logic [CNT_W-1:0] limit   = '0;
   logic             berr_n;
   logic             busy;
`ifdef WATCHDOG_EVCNT_EN
   logic [EVT_W-1:0] evcnt;
`endif

   bus_watchdog #(.CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .as_n    (as_n),
      .dtack_n (dtack_n),
      .limit   (limit),
      .berr_n  (berr_n),
      .busy    (busy)
`ifdef WATCHDOG_EVCNT_EN
      ,
      .evcnt   (evcnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Model: 0 = no cycle watched, 1 = watching, 2 = bus error asserted.
   // Timeout is expressed as an absolute edge number (deadline).
   int     m_mode     = 0;
   longint m_cyc      = 0;
   longint m_deadline = 0;
   int     m_lim      = 0;
   bit     m_armed    = 1'b0;
   int     m_ev       = 0;
   int     m_timeouts = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_lim   = 0;
      m_armed = 1'b0;
      m_ev    = 0;
   endtask

   // Advance the model by one rising edge using the inputs sampled there
   task automatic model_step();
      m_cyc++;
      case (m_mode)
         0: begin
            if (m_armed && !as_n && dtack_n) begin
               m_mode     = 1;
               m_lim      = int'(limit);
               m_deadline = m_cyc + m_lim;
            end
         end
         1: begin
            if (as_n || !dtack_n) begin
               m_mode = 0;
            end else if (m_lim != 0) begin
               if (m_cyc == m_deadline) begin
                  m_mode = 2;
                  m_timeouts++;
                  if (m_ev < EV_MAX) m_ev++;
               end else if (clr) begin
                  m_deadline = m_cyc + m_lim;
               end
            end
         end
         default: begin
            if (as_n) m_mode = 0;
         end
      endcase
      if (as_n) m_armed = 1'b1;
   endtask

   // One clock: drive at negedge, model at posedge, return at next negedge
   task automatic tick(input logic a, input logic d, input logic c);
      as_n    = a;
      dtack_n = d;
      clr     = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between edges, called at a negedge
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_berr_n", 32'(berr_n), 32'd1);
      check("async_rst_busy", 32'(busy), 32'd0);
`ifdef WATCHDOG_EVCNT_EN
      check("async_rst_evcnt", 32'(evcnt), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Per-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_berr_n", 32'(berr_n), 32'(m_mode != 2));
         check("cyc_busy", 32'(busy), 32'(m_mode != 0));
`ifdef WATCHDOG_EVCNT_EN
         check("cyc_evcnt", 32'(evcnt), 32'(m_ev));
`endif
      end
   end

   initial begin
      int t0;
      repeat (2) @(negedge clk);
      check("reset_berr_n", 32'(berr_n), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
`ifdef WATCHDOG_EVCNT_EN
      check("reset_evcnt", 32'(evcnt), 32'd0);
`endif
      rst = 1'b0;
      model_reset();
      chk_en = 1'b1;

      // Plain timeout with limit 5, held until as_n rises
      limit = 8'd5;
      tick(1, 1, 0);
      tick(0, 1, 0);
      check("t5_e0_busy", 32'(busy), 32'd1);
      check("t5_e0_berr_n", 32'(berr_n), 32'd1);
      repeat (4) tick(0, 1, 0);
      check("t5_e4_berr_n", 32'(berr_n), 32'd1);
      tick(0, 1, 0);
      check("t5_e5_berr_n", 32'(berr_n), 32'd0);
      tick(0, 0, 1);
      check("berr_hold_dtack_clr", 32'(berr_n), 32'd0);
      limit = 8'd1;
      tick(0, 1, 0);
      check("berr_hold_busy", 32'(busy), 32'd1);
      tick(1, 1, 0);
      check("berr_release_berr_n", 32'(berr_n), 32'd1);
      check("berr_release_busy", 32'(busy), 32'd0);

      // dtack at edge 3, then dtack racing the timeout at edge 5
      limit = 8'd5;
      repeat (3) tick(0, 1, 0);
      tick(0, 0, 0);
      check("dtack_e3_busy", 32'(busy), 32'd0);
      tick(1, 1, 0);
      repeat (5) tick(0, 1, 0);
      tick(0, 0, 0);
      check("dtack_wins_berr_n", 32'(berr_n), 32'd1);
      check("dtack_wins_busy", 32'(busy), 32'd0);
      tick(1, 1, 0);

      // Kicks at edges 2 and 6 push the timeout to edge 11
      tick(0, 1, 0);
      tick(0, 1, 0);
      tick(0, 1, 1);
      repeat (3) tick(0, 1, 0);
      tick(0, 1, 1);
      repeat (4) tick(0, 1, 0);
      check("kick_e10_berr_n", 32'(berr_n), 32'd1);
      tick(0, 1, 0);
      check("kick_e11_berr_n", 32'(berr_n), 32'd0);
      tick(1, 1, 0);

      // Kick on the timeout edge loses
      repeat (5) tick(0, 1, 0);
      tick(0, 1, 1);
      check("timeout_beats_kick", 32'(berr_n), 32'd0);
      tick(1, 1, 0);

      // limit 0 never times out, even if limit changes mid-cycle
      limit = 8'd0;
      tick(0, 1, 0);
      limit = 8'd3;
      repeat (300) tick(0, 1, 0);
      check("lim0_berr_n", 32'(berr_n), 32'd1);
      check("lim0_busy", 32'(busy), 32'd1);
      tick(1, 1, 0);

      // limit 1 times out on edge 1, then reset during the error
      limit = 8'd1;
      tick(0, 1, 0);
      check("lim1_e0_berr_n", 32'(berr_n), 32'd1);
      tick(0, 1, 0);
      check("lim1_e1_berr_n", 32'(berr_n), 32'd0);
      do_reset();
      repeat (3) tick(0, 1, 0);
      check("post_rst_not_armed", 32'(busy), 32'd0);
      tick(1, 1, 0);
      tick(0, 1, 0);
      check("post_rst_rearmed", 32'(busy), 32'd1);
      tick(1, 1, 0);

      // 20 timeouts saturate the event counter
      do_reset();
      t0 = m_timeouts;
      limit = 8'd1;
      repeat (20) begin
         tick(1, 1, 0);
         tick(0, 1, 0);
         tick(0, 1, 0);
      end
      check("model_20_timeouts", 32'(m_timeouts - t0), 32'd20);
`ifdef WATCHDOG_EVCNT_EN
      check("evcnt_saturated", 32'(evcnt), 32'd15);
`endif
      tick(1, 1, 0);

      // Randomized traffic with limit changing freely
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) limit = CNT_W'($urandom_range(0, 255));
         else limit = CNT_W'($urandom_range(0, 6));
         if ($urandom_range(0, 199) == 0) do_reset();
         tick($urandom_range(0, 9) < 2, $urandom_range(0, 19) != 0,
              $urandom_range(0, 9) == 0);
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_watchdog.md
BUS_WATCHDOG -- requirements
Module: bus_watchdog

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the timeout counter and of the limit input.
REQ-002 SHALL have parameter EVT_W, default 4, meaning width of the timeout event counter (used only with WATCHDOG_EVCNT_EN).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clr  input  1  synchronous kick, restarts count of the current bus cycle.
REQ-006 SHALL have port as_n  input  1  address strobe, low while a bus cycle is active.
REQ-007 SHALL have port dtack_n  input  1  data acknowledge, low terminates the cycle normally.
REQ-008 SHALL have port limit  input  CNT_W  timeout in clocks; 0 disables timeout.
REQ-009 SHALL have port berr_n  output  1  bus error, active-low, registered.
REQ-010 SHALL have port busy  output  1  high while in COUNT or BERR.
REQ-011 SHALL have port evcnt  output  EVT_W  timeout event count; port present only with WATCHDOG_EVCNT_EN.

Function
REQ-012 SHALL implement states IDLE, COUNT, BERR, with registered counter cnt[CNT_W-1:0] and latched limit lim[CNT_W-1:0].
REQ-013 IDLE: SHALL go to COUNT when as_n==0 and dtack_n==1, loading cnt=0 and lim=limit on that edge; otherwise stay IDLE.
REQ-014 IDLE: if as_n==0 and dtack_n==0 on the same edge, SHALL stay IDLE (zero-wait cycle, no count).
REQ-015 COUNT: priority, highest first: (a) as_n==1 or dtack_n==0 -> IDLE, cnt=0; (b) lim==0 -> stay, cnt held; (c) cnt==lim-1 -> BERR; (d) clr==1 -> cnt=0; (e) else cnt=cnt+1.
REQ-016 Timeout SHALL take priority over clr on the same edge; dtack_n low SHALL take priority over timeout on the same edge.
REQ-017 berr_n SHALL go low on the same edge that enters BERR, i.e. the lim-th rising edge after the IDLE->COUNT edge with no kicks.
REQ-018 BERR: berr_n SHALL stay low, clr and dtack_n ignored, until as_n==1 is sampled; then -> IDLE with berr_n=1 on that edge.
REQ-019 Changes to limit while in COUNT or BERR SHALL have no effect until the next IDLE->COUNT entry.
REQ-020 cnt SHALL never wrap; the maximum reachable value is lim-1 (lim=2^CNT_W-1 max).
REQ-021 busy SHALL be registered and equal (state!=IDLE).

Reset
REQ-022 rst high SHALL immediately force state=IDLE, cnt=0, lim=0, berr_n=1, busy=0, evcnt=0, regardless of clk.
REQ-023 rst asserted mid-COUNT or mid-BERR SHALL abort the cycle; after release the block SHALL wait in IDLE for a new as_n low sample, even if as_n stayed low throughout.
REQ-024 To support REQ-023, a flag SHALL block IDLE->COUNT after reset until as_n==1 has been sampled once.

Configuration
REQ-025 Macro WATCHDOG_EVCNT_EN defined: evcnt SHALL increment by 1 on every COUNT->BERR transition, saturating at 2^EVT_W-1, cleared only by rst.
REQ-026 Macro WATCHDOG_EVCNT_EN undefined: evcnt port and its register SHALL not exist; all other behaviour identical.

Verification
REQ-027 limit=5, as_n low at edge 0, dtack_n high -> berr_n low at edge 5, held until as_n high, high on that edge; busy 1 from edge 0.
REQ-028 limit=5, dtack_n low at edge 3 -> no berr_n, IDLE at edge 3; dtack_n low at edge 5 with cnt==4 -> no berr_n (dtack wins).
REQ-029 limit=5, clr pulse at edges 2 and 6 -> berr_n low at edge 11; clr at edge 5 with cnt==4 -> berr_n low at edge 5 (timeout wins).
REQ-030 limit=0, as_n low 300 clocks -> berr_n stays 1, busy stays 1; limit=1 -> berr_n low at edge 1.
REQ-031 rst pulse during BERR with as_n held low -> berr_n 1 immediately, stays IDLE until as_n rises and falls again.
REQ-032 WATCHDOG_EVCNT_EN, EVT_W=4, 20 timeouts -> evcnt reads 15; without macro the same stimulus builds and berr_n waveform is identical.
